// File: rtl/ula_nibble_sequencer.sv
// Drives one 4-bit 74181-style slice over NIBBLES cycles, LSB nibble first, rippling carry
// between nibbles. The wide result, final carry and wide A==B are returned over valid/ready.
module ula_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic [3:0]             req_s,
  input  logic                   req_m,
  input  logic                   req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_f,
  output logic                   rsp_cout,
  output logic                   rsp_eq,
  output logic                   busy,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cin,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cout,
  input  logic                   alu_aeqb
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [3:0]       r_s;
  logic             r_m;
  logic             r_cin;
  logic             r_carry;
  logic             r_eq;
  logic [W-1:0]     r_res;

  logic             w_run;
  logic             w_done;
  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_a_nib [NIBBLES];
  logic [3:0]       w_b_nib [NIBBLES];

  assign w_run    = (r_state == ST_RUN);
  assign w_done   = (r_state == ST_DONE);
  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_last   = (r_idx == IDX_LAST);

  // Operand nibble views so the slice mux is a plain array select on r_idx.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign w_a_nib[gi] = r_a[4*gi +: 4];
      assign w_b_nib[gi] = r_b[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_eq    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_a     <= req_a;
            r_b     <= req_b;
            r_s     <= req_s;
            r_m     <= req_m;
            r_cin   <= req_cin;
            r_idx   <= '0;
            r_eq    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_carry <= alu_cout;
          r_eq    <= r_eq & alu_aeqb;
          if (w_last) begin
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Each result nibble is written only in the cycle its slice pass is presented.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_res
      always_ff @(posedge clk) begin
        if (rst) begin
          r_res[4*gi +: 4] <= 4'd0;
        end else if (w_run && (r_idx == IDX_W'(gi))) begin
          r_res[4*gi +: 4] <= alu_f;
        end
      end
    end
  endgenerate

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = w_run || w_done;
  assign rsp_valid = w_done;
  assign rsp_f     = w_done ? r_res : '0;
  assign rsp_cout  = w_done & r_carry;
  assign rsp_eq    = w_done & r_eq;

  assign alu_a   = w_run ? w_a_nib[r_idx] : 4'd0;
  assign alu_b   = w_run ? w_b_nib[r_idx] : 4'd0;
  assign alu_s   = r_s;
  assign alu_m   = r_m;
  assign alu_cin = w_run && ((r_idx == '0) ? r_cin : r_carry);

endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// Directed bench for ula_nibble_sequencer with a behavioural 74181-style slice
// (active-high data and carry, A=B as a true nibble comparator).
module tb_ula_nibble_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic [3:0]     req_s;
  logic           req_m;
  logic           req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_f;
  logic           rsp_cout;
  logic           rsp_eq;
  logic           busy;
  logic [3:0]     alu_a;
  logic [3:0]     alu_b;
  logic [3:0]     alu_s;
  logic           alu_m;
  logic           alu_cin;
  logic [3:0]     alu_f;
  logic           alu_cout;
  logic           alu_aeqb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ula_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_s     (req_s),
    .req_m     (req_m),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_cout  (rsp_cout),
    .rsp_eq    (rsp_eq),
    .busy      (busy),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_m     (alu_m),
    .alu_cin   (alu_cin),
    .alu_f     (alu_f),
    .alu_cout  (alu_cout),
    .alu_aeqb  (alu_aeqb)
  );

  // Slice model: arithmetic F = X + Y + cin with X = A | (B&S0) | (~B&S1),
  // Y = (A&~B&S2) | (A&B&S3); logic mode uses the 74181 active-high table.
  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [4:0] w_sum;
  always_comb begin
    w_x   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    w_y   = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'd0, alu_cin};
    alu_aeqb = (alu_a == alu_b);
    if (alu_m) begin
      alu_cout = 1'b0;
      case (alu_s)
        4'b0000: alu_f = ~alu_a;
        4'b0001: alu_f = ~(alu_a | alu_b);
        4'b0010: alu_f = ~alu_a & alu_b;
        4'b0011: alu_f = 4'h0;
        4'b0100: alu_f = ~(alu_a & alu_b);
        4'b0101: alu_f = ~alu_b;
        4'b0110: alu_f = alu_a ^ alu_b;
        4'b0111: alu_f = alu_a & ~alu_b;
        4'b1000: alu_f = ~alu_a | alu_b;
        4'b1001: alu_f = ~(alu_a ^ alu_b);
        4'b1010: alu_f = alu_b;
        4'b1011: alu_f = alu_a & alu_b;
        4'b1100: alu_f = 4'hF;
        4'b1101: alu_f = alu_a | ~alu_b;
        4'b1110: alu_f = alu_a | alu_b;
        default: alu_f = alu_a;
      endcase
    end else begin
      alu_f    = w_sum[3:0];
      alu_cout = w_sum[4];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for req_ready at a falling edge, then presents one request for one edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic m, input logic cin);
    int waited = 0;
    while (!req_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("issue_ready", 32'(req_ready), 32'd1);
    req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Samples alu_cin for each nibble pass; returns at the falling edge where rsp_valid must be up.
  task automatic collect(output logic [NIB-1:0] seq);
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      seq[k] = alu_cin;
      check("run_no_valid", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    check("latency_valid", 32'(rsp_valid), 32'd1);
  endtask

  logic [NIB-1:0] seq;
  logic [W-1:0]   hold_f;
  int             seen;
  int             nreq;
  int             nrsp;
  int             acc_cyc [3];
  logic [W-1:0]   v_a   [3];
  logic [W-1:0]   v_b   [3];
  logic [3:0]     v_s   [3];
  logic           v_m   [3];
  logic [W-1:0]   v_f   [3];
  logic           v_co  [3];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = '0;
    req_m = 1'b0; req_cin = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_f", 32'(rsp_f), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_alu_cin", 32'(alu_cin), 32'd0);

    // Arithmetic ripple: (A|B)+A with B=0 doubles A.
    issue(16'h00FF, 16'h0000, 4'b1101, 1'b0, 1'b0);
    collect(seq);
    check("t1_cin_seq", 32'(seq), 32'h6);
    check("t1_f", 32'(rsp_f), 32'h01FE);
    check("t1_cout", 32'(rsp_cout), 32'd0);
    check("t1_eq", 32'(rsp_eq), 32'd0);
    @(negedge clk);
    check("t1_consumed", 32'(rsp_valid), 32'd0);
    check("t1_idle_ready", 32'(req_ready), 32'd1);

    // Decrement across nibbles.
    issue(16'h0100, 16'h0000, 4'b1111, 1'b0, 1'b0);
    collect(seq);
    check("t2a_cin_seq", 32'(seq), 32'h8);
    check("t2a_f", 32'(rsp_f), 32'h00FF);
    check("t2a_cout", 32'(rsp_cout), 32'd1);
    issue(16'h0000, 16'h0000, 4'b1111, 1'b0, 1'b0);
    collect(seq);
    check("t2b_f", 32'(rsp_f), 32'hFFFF);
    check("t2b_cout", 32'(rsp_cout), 32'd0);

    // Logic mode and equality.
    issue(16'hA5A5, 16'h5A5A, 4'b0110, 1'b1, 1'b0);
    collect(seq);
    check("t3a_f", 32'(rsp_f), 32'hFFFF);
    check("t3a_cout", 32'(rsp_cout), 32'd0);
    check("t3a_eq", 32'(rsp_eq), 32'd0);
    issue(16'h1234, 16'h1234, 4'b1111, 1'b1, 1'b0);
    collect(seq);
    check("t3b_f", 32'(rsp_f), 32'h1234);
    check("t3b_eq", 32'(rsp_eq), 32'd1);
    check("t3b_alu_s", 32'(alu_s), 32'hF);
    check("t3b_alu_m", 32'(alu_m), 32'd1);
    check("t3b_alu_a_idle", 32'(alu_a), 32'd0);

    // Backpressure: response holds, a request presented meanwhile is ignored.
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(16'h0F0F, 16'h0F0F, 4'b1111, 1'b1, 1'b0);
    collect(seq);
    hold_f = rsp_f;
    check("t4_f", 32'(hold_f), 32'h0F0F);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        req_a = 16'hFFFF; req_valid = 1'b1;
      end
      @(negedge clk);
      req_valid = 1'b0;
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_f", 32'(rsp_f), 32'h0F0F);
      check("t4_hold_eq", 32'(rsp_eq), 32'd1);
      check("t4_no_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", 32'(rsp_valid), 32'd0);
    check("t4_release_ready", 32'(req_ready), 32'd1);
    issue(16'hFFFF, 16'h0000, 4'b1111, 1'b1, 1'b0);
    collect(seq);
    check("t4_new_f", 32'(rsp_f), 32'hFFFF);
    check("t4_new_eq", 32'(rsp_eq), 32'd0);

    // Reset in the middle of RUN discards the operation.
    issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_valid", 32'(rsp_valid), 32'd0);
    check("t5_f", 32'(rsp_f), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("t5_no_rsp", 32'(seen), 32'd0);

    // Back-to-back with req_valid held high.
    v_a[0] = 16'h1234; v_b[0] = 16'h1111; v_s[0] = 4'b1001; v_m[0] = 1'b0; v_f[0] = 16'h2345; v_co[0] = 1'b0;
    v_a[1] = 16'hFFFF; v_b[1] = 16'h0001; v_s[1] = 4'b1001; v_m[1] = 1'b0; v_f[1] = 16'h0000; v_co[1] = 1'b1;
    v_a[2] = 16'hF0F0; v_b[2] = 16'hFF00; v_s[2] = 4'b0110; v_m[2] = 1'b1; v_f[2] = 16'h0FF0; v_co[2] = 1'b0;
    nreq = 0;
    nrsp = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rsp_valid && nrsp < 3) begin
        check("t6_f", 32'(rsp_f), 32'(v_f[nrsp]));
        check("t6_cout", 32'(rsp_cout), 32'(v_co[nrsp]));
        nrsp++;
      end
      if (nreq < 3) begin
        req_a = v_a[nreq]; req_b = v_b[nreq]; req_s = v_s[nreq];
        req_m = v_m[nreq]; req_cin = 1'b0; req_valid = 1'b1;
        if (req_ready) begin
          acc_cyc[nreq] = cyc;
          nreq++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    check("t6_nreq", 32'(nreq), 32'd3);
    check("t6_nrsp", 32'(nrsp), 32'd3);
    if (nreq == 3) begin
      check("t6_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("t6_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ula_nibble_sequencer.md
Name: ula_nibble_sequencer

Overview:
- Multi-cycle controller that computes NIBBLES*4-bit operations on the team's single 4-bit 74181-style ALU slice (inputs a, b, s, m, c_in; outputs f, c_out, a_eq_b).
- Each cycle it presents one operand nibble, LSB nibble first, and ripples the slice's carry-out into the next nibble's carry-in.
- It assembles the wide result, the final carry and a wide A=B flag, and returns them over a valid/ready response interface.
- It sits between the instruction/control logic and the ALU slice.

Parameters:
NIBBLES, 4, number of 4-bit slices sequenced; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request (high only in IDLE)
req_a  input  W  operand A
req_b  input  W  operand B
req_s  input  4  function select {S3,S2,S1,S0}, passed to slice unchanged
req_m  input  1  1 = logic mode, 0 = arithmetic mode
req_cin  input  1  carry-in applied to nibble 0
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_f  output  W  assembled result
rsp_cout  output  1  carry-out of the most significant nibble
rsp_eq  output  1  AND of slice a_eq_b over all nibbles (wide A==B)
busy  output  1  high in RUN or DONE
alu_a  output  4  nibble of A to slice
alu_b  output  4  nibble of B to slice
alu_s  output  4  latched function select
alu_m  output  1  latched mode
alu_cin  output  1  carry into slice
alu_f  input  4  slice result
alu_cout  input  1  slice carry-out
alu_aeqb  input  1  slice A=B

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, idx=0, carry_reg=0, eq_reg=1, result register=0; rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_eq=0, busy=0. req_ready=1 from the first cycle after reset.
- Reset mid-operation (RUN or DONE) aborts the operation. The pending result is discarded and never presented.
- States:
  - IDLE: req_ready=1. On req_valid: latch a, b, s, m, cin; set idx=0, eq_reg=1; go to RUN.
  - RUN: each cycle drives alu_a=A[4*idx+:4], alu_b=B[4*idx+:4], alu_s and alu_m from the latched values, and alu_cin = (idx==0) ? latched cin : carry_reg. The slice is combinational, so at each edge: res[4*idx+:4] <= alu_f, carry_reg <= alu_cout, eq_reg <= eq_reg & alu_aeqb, idx <= idx+1. At the edge where idx==NIBBLES-1, go to DONE.
  - DONE: rsp_valid=1; rsp_f, rsp_cout (= last captured alu_cout) and rsp_eq are stable. On rsp_ready, go to IDLE and clear rsp_valid.
- alu_* ports outside RUN: alu_a=alu_b=0, alu_cin=0, alu_s and alu_m hold their last latched values.
- Latency: rsp_valid rises exactly NIBBLES cycles after the accepting edge. Minimum issue interval is NIBBLES+2 cycles. A new request cannot be accepted in the same cycle the response is consumed.
- Carry is forwarded raw from the slice. The sequencer does not reinterpret the slice's carry polarity for any select code. In logic mode the slice drives c_out=0, so rsp_cout=0.
- Request fields are ignored outside IDLE. Response fields hold while rsp_ready=0, with no timeout.
- idx width is clog2(NIBBLES). idx never exceeds NIBBLES-1.

Test Plan:
1. Arithmetic ripple, NIBBLES=4: m=0, s=1101, a=0x00FF, b=0x0000, cin=0 -> alu_cin sequence 0,1,1,0; rsp_f=0x01FE, rsp_cout=0, rsp_eq=0; rsp_valid 4 cycles after acceptance.
2. Decrement across nibbles: m=0, s=1111, a=0x0100, cin=0 -> rsp_f=0x00FF, rsp_cout=1. Same with a=0x0000 -> rsp_f=0xFFFF, rsp_cout=0.
3. Logic mode and equality: m=1, s=0110, a=0xA5A5, b=0x5A5A -> rsp_f=0xFFFF, rsp_cout=0, rsp_eq=0. Then m=1, s=1111, a=b=0x1234 -> rsp_f=0x1234, rsp_eq=1.
4. Backpressure: hold rsp_ready=0 for 6 cycles after rsp_valid -> rsp_valid=1, outputs unchanged, req_ready=0, and a req_valid pulse with a=0xFFFF is not accepted. Release rsp_ready -> IDLE next cycle, then the new request is accepted.
5. Reset mid-RUN: assert rst for 1 cycle at idx=2 -> next cycle IDLE, rsp_valid=0, rsp_f=0, busy=0, req_ready=1. No response appears for the aborted request.
6. Back-to-back: issue 3 requests with req_valid held high and rsp_ready=1 -> acceptances spaced 6 cycles apart, responses in order with correct values.
